// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
// MULT/DIV results land WIDTH+1 edges after accept with a done pulse; MTHI/MTLO write in one edge.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand conditioning: signed ops work on magnitudes, sign fixed up at the end.
    logic               signed_op;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign signed_op = ~op[0];
    assign sign_a    = signed_op & rs_data[WIDTH-1];
    assign sign_b    = signed_op & rt_data[WIDTH-1];
    assign mag_a     = sign_a ? -rs_data : rs_data;
    assign mag_b     = sign_b ? -rt_data : rt_data;

    // acc holds {upper partial (WIDTH+1), lower WIDTH}: product bits for mult,
    // {remainder, dividend/quotient} for div.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = {1'b0, rem_sh} - {2'b00, b_q};
    assign prod     = acc_q[2*WIDTH-1:0];
    assign prod_fix = neg_q ? -prod : prod;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = (state_q == S_RUN);
        done_d    = (state_q == S_FINISH);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            acc_d     = {{(WIDTH+1){1'b0}}, mag_a};
                            b_d       = mag_b;
                            count_d   = '0;
                            is_div_d  = op[1];
                            neg_d     = sign_a ^ sign_b;
                            rem_neg_d = sign_a;
                            div0_d    = op[1] & (rt_data == '0);
                            state_d   = S_RUN;
                        end
                        3'b100:  hi_d = rs_data;
                        3'b101:  lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring step: keep the subtraction only when it did not borrow.
                    acc_d = diff[WIDTH+1] ? {rem_sh, acc_q[WIDTH-2:0], 1'b0}
                                          : {diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (is_div_q) begin
                    // A zero divisor leaves rem == |rs|; restoring rs's sign yields rs itself.
                    lo_d = div0_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
                    hi_d = rem_neg_q ? -rem : rem;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
